// File: rtl/elc3_mem_ctrl_if.sv
// Datapath-side handshake bundle of the eLC-3 memory/IO controller.
// The control FSM drives the master side; the controller implements the slave side.
interface elc3_mem_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              MIO_EN;
  logic              R_W;
  logic [ADDR_W-1:0] MAR;
  logic [DATA_W-1:0] MDR_wr;
  logic [DATA_W-1:0] MDR_rd;
  logic              R;
  logic              Busy;

  modport master (
    output MIO_EN, R_W, MAR, MDR_wr,
    input  MDR_rd, R, Busy
  );

  modport slave (
    input  MIO_EN, R_W, MAR, MDR_wr,
    output MDR_rd, R, Busy
  );
endinterface

// File: rtl/elc3_mem_ctrl.sv
// eLC-3 memory/IO access controller: multi-cycle SRAM handshake with wait states,
// plus memory-mapped switches (synchronised) and an LED register above IO_BASE.
module elc3_mem_ctrl #(
  parameter int                DATA_W      = 16,
  parameter int                ADDR_W      = 16,
  parameter int                WAIT_CYCLES = 2,
  parameter logic [ADDR_W-1:0] IO_BASE     = 16'hFE00,
  parameter int                NUM_SW      = 18,
  parameter int                NUM_LED     = 18
) (
  input  logic               Clk,
  input  logic               Reset_n,
  elc3_mem_ctrl_if.slave     cpu,
  output logic [ADDR_W-1:0]  Mem_addr,
  output logic [DATA_W-1:0]  Mem_wdata,
  input  logic [DATA_W-1:0]  Mem_rdata,
  output logic               Mem_CE_n,
  output logic               Mem_OE_n,
  output logic               Mem_WE_n,
  input  logic [NUM_SW-1:0]  SW,
  output logic [NUM_LED-1:0] LEDR
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rw_q, rw_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  mdr_q, mdr_d;
  logic [NUM_LED-1:0] led_q, led_d;
  logic [NUM_SW-1:0]  sw_s1_q, sw_s2_q;
  logic               r_q, r_d;
  logic               busy_q, busy_d;
  logic               ce_n_q, ce_n_d;
  logic               oe_n_q, oe_n_d;
  logic               we_n_q, we_n_d;

  logic               is_io_s;
  logic [ADDR_W-1:0]  io_off_s;
  logic [DATA_W-1:0]  io_rdata_s;
  logic               strobe_s;
  logic               unused_sw_s;

  assign is_io_s  = (cpu.MAR >= IO_BASE);
  assign io_off_s = cpu.MAR - IO_BASE;

  // Upper switch bits are dropped when NUM_SW exceeds DATA_W.
  assign unused_sw_s = ^sw_s2_q;

  // IO read mux: offset 0 switches, offset 1 LED register, anything else reads zero.
  always_comb begin
    io_rdata_s = {DATA_W{1'b0}};
    if (io_off_s == {ADDR_W{1'b0}}) begin
      io_rdata_s = DATA_W'(sw_s2_q);
    end else if (io_off_s == ADDR_W'(1)) begin
      io_rdata_s = DATA_W'(led_q);
    end else begin
      io_rdata_s = {DATA_W{1'b0}};
    end
  end

  // Access FSM next-state, latched request fields and registered-output next values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mdr_d   = mdr_q;
    led_d   = led_q;

    case (state_q)
      S_IDLE: begin
        if (cpu.MIO_EN) begin
          rw_d = cpu.R_W;
          if (is_io_s) begin
            state_d = S_DONE;
            if (cpu.R_W) begin
              if (io_off_s == ADDR_W'(1)) begin
                led_d = NUM_LED'(cpu.MDR_wr);
              end else begin
                led_d = led_q;
              end
            end else begin
              mdr_d = io_rdata_s;
            end
          end else begin
            state_d = S_SETUP;
            addr_d  = cpu.MAR;
            wdata_d = cpu.MDR_wr;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        if (WAIT_CYCLES == 0) begin
          state_d = S_DONE;
          if (!rw_q) begin
            mdr_d = Mem_rdata;
          end else begin
            mdr_d = mdr_q;
          end
        end else begin
          state_d = S_WAIT;
          cnt_d   = WAIT_LOAD;
        end
      end
      S_WAIT: begin
        // Read data is sampled on the edge that leaves the last strobed cycle.
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = S_DONE;
          if (!rw_q) begin
            mdr_d = Mem_rdata;
          end else begin
            mdr_d = mdr_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    strobe_s = (state_d == S_SETUP) || (state_d == S_WAIT);
    ce_n_d   = !strobe_s;
    oe_n_d   = !(strobe_s && !rw_d);
    we_n_d   = !(strobe_s && rw_d);
    r_d      = (state_d == S_DONE);
    busy_d   = (state_d != S_IDLE);
  end

  // State, datapath registers, registered strobes and the switch synchroniser.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      rw_q    <= 1'b0;
      addr_q  <= {ADDR_W{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
      mdr_q   <= {DATA_W{1'b0}};
      led_q   <= {NUM_LED{1'b0}};
      sw_s1_q <= {NUM_SW{1'b0}};
      sw_s2_q <= {NUM_SW{1'b0}};
      r_q     <= 1'b0;
      busy_q  <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mdr_q   <= mdr_d;
      led_q   <= led_d;
      sw_s1_q <= SW;
      sw_s2_q <= sw_s1_q;
      r_q     <= r_d;
      busy_q  <= busy_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
    end
  end

  assign cpu.MDR_rd = mdr_q;
  assign cpu.R      = r_q;
  assign cpu.Busy   = busy_q;
  assign Mem_addr   = addr_q;
  assign Mem_wdata  = wdata_q;
  assign Mem_CE_n   = ce_n_q;
  assign Mem_OE_n   = oe_n_q;
  assign Mem_WE_n   = we_n_q;
  assign LEDR       = led_q;

endmodule

// File: tb/tb_elc3_mem_ctrl.sv
// Self-checking bench for elc3_mem_ctrl: transaction-level reference model plus directed
// literal scenarios on a WAIT_CYCLES=2 instance, and a WAIT_CYCLES=0 instance for latency.
module tb_elc3_mem_ctrl;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int W  = 2;
  localparam int NSW = 18;
  localparam int NLED = 18;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  elc3_mem_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus2 ();
  elc3_mem_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();

  logic [AW-1:0]   addr2, addr0;
  logic [DW-1:0]   wd2, wd0;
  logic [DW-1:0]   rdata;
  logic            ce2, oe2, we2, ce0, oe0, we0;
  logic [NSW-1:0]  sw;
  logic [NLED-1:0] led2, led0;

  elc3_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(W), .IO_BASE(16'hFE00),
                  .NUM_SW(NSW), .NUM_LED(NLED)) u_dut2 (
    .Clk(Clk), .Reset_n(Reset_n), .cpu(bus2),
    .Mem_addr(addr2), .Mem_wdata(wd2), .Mem_rdata(rdata),
    .Mem_CE_n(ce2), .Mem_OE_n(oe2), .Mem_WE_n(we2),
    .SW(sw), .LEDR(led2)
  );

  elc3_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(0), .IO_BASE(16'hFE00),
                  .NUM_SW(NSW), .NUM_LED(NLED)) u_dut0 (
    .Clk(Clk), .Reset_n(Reset_n), .cpu(bus0),
    .Mem_addr(addr0), .Mem_wdata(wd0), .Mem_rdata(rdata),
    .Mem_CE_n(ce0), .Mem_OE_n(oe0), .Mem_WE_n(we0),
    .SW(sw), .LEDR(led0)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Reference model: one accepted request produces a known schedule relative to its accept cycle.
  int              cyc = 0;
  bit              m_busy = 1'b0;
  int              m_acc = 0;
  int              m_lat = 0;
  bit              m_io = 1'b0;
  bit              m_rw = 1'b0;
  logic [15:0]     m_mdr = 16'h0;
  logic [17:0]     m_led = 18'h0;
  logic [15:0]     m_maddr = 16'h0;
  logic [15:0]     m_mwd = 16'h0;
  logic [17:0]     h1 = 18'h0;
  logic [17:0]     h2 = 18'h0;

  always @(negedge Clk) begin
    int          d;
    bit          idle;
    bit          strobe;
    bit          exp_r;
    logic [15:0] off;
    cyc++;
    if (!Reset_n) begin
      m_busy = 1'b0; m_mdr = 16'h0; m_led = 18'h0;
      m_maddr = 16'h0; m_mwd = 16'h0; h1 = 18'h0; h2 = 18'h0;
    end
    d      = cyc - m_acc;
    exp_r  = m_busy && (d == m_lat);
    strobe = m_busy && !m_io && (d <= W + 1);
    chk("busy", 32'(bus2.Busy), 32'(m_busy));
    chk("R", 32'(bus2.R), 32'(exp_r));
    chk("CE_n", 32'(ce2), 32'(!strobe));
    chk("OE_n", 32'(oe2), 32'(!(strobe && !m_rw)));
    chk("WE_n", 32'(we2), 32'(!(strobe && m_rw)));
    chk("MDR_rd", 32'(bus2.MDR_rd), 32'(m_mdr));
    chk("LEDR", 32'(led2), 32'(m_led));
    if (!Reset_n || (m_busy && !m_io)) begin
      chk("Mem_addr", 32'(addr2), 32'(m_maddr));
      chk("Mem_wdata", 32'(wd2), 32'(m_mwd));
    end
    if (Reset_n) begin
      if (m_busy && !m_io && !m_rw && (d == m_lat - 1)) m_mdr = rdata;
      idle = !m_busy;
      if (m_busy && (d == m_lat)) m_busy = 1'b0;
      if (idle && bus2.MIO_EN) begin
        m_busy = 1'b1;
        m_acc  = cyc;
        m_rw   = bus2.R_W;
        m_io   = (bus2.MAR >= 16'hFE00);
        if (m_io) begin
          m_lat = 1;
          off   = bus2.MAR - 16'hFE00;
          if (m_rw) begin
            if (off == 16'd1) m_led = {2'b00, bus2.MDR_wr};
          end else begin
            m_mdr = (off == 16'd0) ? h2[15:0] : (off == 16'd1) ? m_led[15:0] : 16'h0000;
          end
        end else begin
          m_lat   = W + 2;
          m_maddr = bus2.MAR;
          m_mwd   = bus2.MDR_wr;
        end
      end
      h2 = h1;
      h1 = sw;
    end
  end

  // Per-cycle logs of one directed transaction (bit k = cycle k after accept).
  logic [9:0]  r_m, ce_m, oe_m, we_m, r0_m, ce0_m;
  logic [15:0] mdr_l [10];
  logic [15:0] maddr_l [10];
  logic [15:0] mwd_l [10];
  logic [15:0] mdr0_l [10];
  logic [17:0] led_l [10];

  task automatic txn(input bit rw, input logic [15:0] a, input logic [15:0] wdat,
                     input logic [15:0] rd, input bit hold, input bit chg, input logic [15:0] a2);
    bus2.MIO_EN = 1'b1; bus2.R_W = rw; bus2.MAR = a; bus2.MDR_wr = wdat;
    bus0.MIO_EN = 1'b1; bus0.R_W = rw; bus0.MAR = a; bus0.MDR_wr = wdat;
    rdata = rd;
    for (int k = 0; k < 10; k++) begin
      @(negedge Clk);
      r_m[k] = bus2.R; ce_m[k] = !ce2; oe_m[k] = !oe2; we_m[k] = !we2;
      mdr_l[k] = bus2.MDR_rd; maddr_l[k] = addr2; mwd_l[k] = wd2; led_l[k] = led2;
      r0_m[k] = bus0.R; ce0_m[k] = !ce0; mdr0_l[k] = bus0.MDR_rd;
      tick();
      bus0.MIO_EN = 1'b0;
      if (r_m[k] && !hold) bus2.MIO_EN = 1'b0;
      if (chg && k == 1) bus2.MAR = a2;
    end
    bus2.MIO_EN = 1'b0;
  endtask

  initial begin
    logic r_seen;
    bus2.MIO_EN = 1'b0; bus2.R_W = 1'b0; bus2.MAR = 16'h0; bus2.MDR_wr = 16'h0;
    bus0.MIO_EN = 1'b0; bus0.R_W = 1'b0; bus0.MAR = 16'h0; bus0.MDR_wr = 16'h0;
    rdata = 16'h0; sw = 18'h0;
    repeat (3) tick();
    @(negedge Clk);
    chk("rst_busy", 32'(bus2.Busy), 32'h0);
    chk("rst_strobes", 32'({ce2, oe2, we2}), 32'h7);
    chk("rst_mdr", 32'(bus2.MDR_rd), 32'h0);
    tick();
    Reset_n = 1'b1;
    tick();

    // T1 / T4: SRAM read of 3000 on both instances
    txn(1'b0, 16'h3000, 16'h0000, 16'hBEEF, 1'b0, 1'b0, 16'h0);
    chk("T1_R", 32'(r_m), 32'(10'b0000010000));
    chk("T1_CE", 32'(ce_m), 32'(10'b0000001110));
    chk("T1_OE", 32'(oe_m), 32'(10'b0000001110));
    chk("T1_WE", 32'(we_m), 32'h0);
    chk("T1_MDR_pre", 32'(mdr_l[3]), 32'h0);
    chk("T1_MDR", 32'(mdr_l[4]), 32'hBEEF);
    chk("T4_R", 32'(r0_m), 32'(10'b0000000100));
    chk("T4_CE", 32'(ce0_m), 32'(10'b0000000010));
    chk("T4_MDR", 32'(mdr0_l[2]), 32'hBEEF);

    // T2: SRAM write
    txn(1'b1, 16'h3001, 16'h1234, 16'h5555, 1'b0, 1'b0, 16'h0);
    chk("T2_WE", 32'(we_m), 32'(10'b0000001110));
    chk("T2_OE", 32'(oe_m), 32'h0);
    chk("T2_R", 32'(r_m), 32'(10'b0000010000));
    chk("T2_addr", 32'(maddr_l[2]), 32'h3001);
    chk("T2_wdata", 32'(mwd_l[2]), 32'h1234);
    chk("T2_MDR", 32'(mdr_l[9]), 32'hBEEF);

    // T3: LED write/read and switch read
    txn(1'b1, 16'hFE01, 16'h0005, 16'h0, 1'b0, 1'b0, 16'h0);
    chk("T3_R", 32'(r_m), 32'(10'b0000000010));
    chk("T3_strobes", 32'(ce_m | oe_m | we_m), 32'h0);
    chk("T3_LED", 32'(led_l[1]), 32'h00005);
    txn(1'b0, 16'hFE01, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
    chk("T3_LEDrd", 32'(mdr_l[1]), 32'h0005);
    sw = 18'h2A5A5;
    repeat (2) tick();
    txn(1'b0, 16'hFE00, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
    chk("T3_SW", 32'(mdr_l[1]), 32'hA5A5);

    // T4: unmapped IO read; FFFF is IO, FDFF is SRAM
    txn(1'b0, 16'hFE07, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
    chk("T4_io_R", 32'(r0_m), 32'(10'b0000000010));
    chk("T4_io_MDR", 32'(mdr0_l[1]), 32'h0);
    txn(1'b0, 16'hFFFF, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
    chk("FFFF_R", 32'(r_m), 32'(10'b0000000010));
    chk("FFFF_strobes", 32'(ce_m), 32'h0);
    txn(1'b0, 16'hFDFF, 16'h0, 16'h1357, 1'b0, 1'b0, 16'h0);
    chk("FDFF_R", 32'(r_m), 32'(10'b0000010000));
    chk("FDFF_MDR", 32'(mdr_l[4]), 32'h1357);

    // T6: MIO_EN held across R, MAR changed mid-access
    txn(1'b0, 16'h4000, 16'h0, 16'hCAFE, 1'b1, 1'b1, 16'h4444);
    chk("T6_R", 32'(r_m), 32'(10'b1000010000));
    chk("T6_OE", 32'(oe_m), 32'(10'b0111001110));
    chk("T6_addr1", 32'(maddr_l[4]), 32'h4000);
    chk("T6_addr2", 32'(maddr_l[6]), 32'h4444);
    chk("T6_MDR", 32'(mdr_l[9]), 32'hCAFE);

    // T5: reset during WAIT of a write
    bus2.MIO_EN = 1'b1; bus2.R_W = 1'b1; bus2.MAR = 16'h3002; bus2.MDR_wr = 16'h9999;
    tick();
    tick();
    Reset_n = 1'b0;
    bus2.MIO_EN = 1'b0;
    #1;
    chk("T5_strobes", 32'({ce2, we2}), 32'h3);
    chk("T5_R", 32'(bus2.R), 32'h0);
    tick();
    Reset_n = 1'b1;
    r_seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge Clk);
      r_seen = r_seen | bus2.R;
      tick();
    end
    chk("T5_noR", 32'(r_seen), 32'h0);
    chk("T5_busy", 32'(bus2.Busy), 32'h0);
    chk("T5_LED", 32'(led2), 32'h0);
    chk("T5_MDR", 32'(bus2.MDR_rd), 32'h0);

    // Randomised traffic, including changes while busy and occasional resets
    for (int i = 0; i < 3000; i++) begin
      int sel;
      sel = $urandom_range(0, 7);
      bus2.MIO_EN = ($urandom_range(0, 3) != 0);
      bus2.R_W    = 1'($urandom_range(0, 1));
      bus2.MDR_wr = 16'($urandom);
      rdata       = 16'($urandom);
      sw          = 18'($urandom);
      case (sel)
        4:       bus2.MAR = 16'hFE00;
        5:       bus2.MAR = 16'hFE01;
        6:       bus2.MAR = 16'($urandom_range(32'hFE02, 32'hFFFF));
        7:       bus2.MAR = 16'hFFFF;
        default: bus2.MAR = 16'($urandom_range(0, 32'hFDFF));
      endcase
      Reset_n = ($urandom_range(0, 499) != 0);
      tick();
    end
    Reset_n = 1'b1;
    bus2.MIO_EN = 1'b0;
    repeat (8) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
